// File: rtl/bcd_accum_display.sv
// bcd_accum_display
//   Decimal accumulator fed by the upstream BCD counter/remap stage, with a
//   time-multiplexed, active-low 7-segment display of the running total.
//
// Parameters:
//   NDIG      number of BCD digits in the accumulator and display (1..4)
//   SCAN_DIV  clock cycles each display digit stays lit (>= 1)
//
// Ports:
//   clk       system clock, everything on posedge
//   rst       synchronous active-high reset
//   in_valid  in_digit is presented this cycle
//   in_digit  BCD digit to add into the accumulator
//   clr       synchronous clear of accumulator and flags
//   acc       packed BCD accumulator, digit k in bits [4k+3:4k], k=0 units
//   ovf       sticky decimal overflow flag
//   err       sticky illegal (non-BCD) input flag
//   an        digit enables, active-low one-hot
//   seg       segments {g,f,e,d,c,b,a}, active-low
module bcd_accum_display #(
  parameter int NDIG     = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_digit,
  input  logic              clr,
  output logic [4*NDIG-1:0] acc,
  output logic              ovf,
  output logic              err,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]     presc;
  logic [PW-1:0]     presc_next;
  logic [IDXW-1:0]   scan_idx;
  logic [IDXW-1:0]   scan_idx_next;
  logic [4*NDIG-1:0] sum_acc;
  logic              sum_carry;
  logic [4:0]        dsum;
  logic [3:0]        shown_digit;
  logic [NDIG-1:0]   an_next;

  // Active-low glyphs; the blank default is unreachable because acc only
  // ever holds legal BCD nibbles.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Ripple decimal add: the incoming digit enters at the units position and
  // each digit that exceeds 9 is folded back by 10 with a carry upward. The
  // carry out of the top digit is the overflow indication.
  always_comb begin
    sum_acc = '0;
    sum_carry = 1'b0;
    dsum = '0;
    for (int k = 0; k < NDIG; k++) begin
      dsum = {1'b0, acc[4*k +: 4]} + {4'b0000, sum_carry};
      if (k == 0) dsum = dsum + {1'b0, in_digit};
      if (dsum > 5'd9) begin
        dsum = dsum - 5'd10;
        sum_carry = 1'b1;
      end else begin
        sum_carry = 1'b0;
      end
      sum_acc[4*k +: 4] = dsum[3:0];
    end
  end

  // Scan sequencing. The display registers are loaded from the *next* scan
  // index so that an, seg and the index all change on the same edge and
  // every slot, including the first after reset, lasts exactly SCAN_DIV.
  always_comb begin
    presc_next = presc + PW'(1);
    scan_idx_next = scan_idx;
    if (presc == PW'(SCAN_DIV - 1)) begin
      presc_next = '0;
      if (scan_idx == IDXW'(NDIG - 1)) scan_idx_next = '0;
      else scan_idx_next = scan_idx + IDXW'(1);
    end
  end

  always_comb begin
    shown_digit = 4'd0;
    an_next = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (scan_idx_next == IDXW'(k)) begin
        shown_digit = acc[4*k +: 4];
        an_next[k] = 1'b0;
      end
    end
  end

  // Accumulator and sticky flags: rst beats clr beats in_valid. An illegal
  // digit only raises err; acc and ovf are left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else if (in_valid) begin
      if (in_digit > 4'd9) begin
        err <= 1'b1;
      end else begin
        acc <= sum_acc;
        if (sum_carry) ovf <= 1'b1;
      end
    end
  end

  // Display scan registers; clr deliberately has no effect here.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      scan_idx <= '0;
      an <= {{(NDIG-1){1'b1}}, 1'b0};
      seg <= 7'b1000000;
    end else begin
      presc <= presc_next;
      scan_idx <= scan_idx_next;
      an <= an_next;
      seg <= seg7(shown_digit);
    end
  end

endmodule

// File: tb/tb_bcd_accum_display.sv
// tb_bcd_accum_display
//   Table-driven bench for bcd_accum_display (NDIG=2, SCAN_DIV=4) plus
//   hand-written sequences for display scanning and mid-scan reset.
module tb_bcd_accum_display;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       clr;
  logic [7:0] acc;
  logic       ovf;
  logic       err;
  logic [1:0] an;
  logic [6:0] seg;

  int compared;
  int mismatched;

  typedef struct {
    logic       clr;
    logic       valid;
    logic [3:0] digit;
    logic [7:0] exp_acc;
    logic       exp_ovf;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  bcd_accum_display #(.NDIG(2), .SCAN_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_digit(in_digit),
    .clr(clr),
    .acc(acc),
    .ovf(ovf),
    .err(err),
    .an(an),
    .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected glyphs, written out independently of the design
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
    tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
    tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
    tbl[9] = 7'b0010000;
    return tbl[d];
  endfunction

  task automatic addVec(input logic c, input logic v, input logic [3:0] d,
                        input logic [7:0] ea, input logic eo, input logic ee);
    vec_t r;
    r.clr = c; r.valid = v; r.digit = d;
    r.exp_acc = ea; r.exp_ovf = eo; r.exp_err = ee;
    vecs.push_back(r);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let one posedge pass, return at the negedge
  task automatic applyStimulus(input logic r, input logic c, input logic v,
                               input logic [3:0] d);
    rst = r; clr = c; in_valid = v; in_digit = d;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_digit = 4'd0;
  endtask

  task automatic checkAccFlags(input string tag, input logic [7:0] ea,
                               input logic eo, input logic ee);
    checkOutput({tag, ".acc"}, {24'd0, acc}, {24'd0, ea});
    checkOutput({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, ee});
  endtask

  initial begin
    logic [1:0] start_an;
    logic [1:0] slot_an;
    logic [6:0] slot_seg;
    bit         found;

    compared = 0;
    mismatched = 0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_digit = 4'd0;

    // Accumulation, wrap/overflow, illegal digit and clr vectors
    addVec(0, 1, 4'd7, 8'h07, 0, 0);
    addVec(0, 1, 4'd8, 8'h15, 0, 0);
    addVec(0, 0, 4'd9, 8'h15, 0, 0);
    addVec(1, 0, 4'd0, 8'h00, 0, 0);
    addVec(0, 1, 4'd9, 8'h09, 0, 0);
    addVec(0, 1, 4'd9, 8'h18, 0, 0);
    addVec(0, 1, 4'd9, 8'h27, 0, 0);
    addVec(0, 1, 4'd9, 8'h36, 0, 0);
    addVec(0, 1, 4'd9, 8'h45, 0, 0);
    addVec(0, 1, 4'd9, 8'h54, 0, 0);
    addVec(0, 1, 4'd9, 8'h63, 0, 0);
    addVec(0, 1, 4'd9, 8'h72, 0, 0);
    addVec(0, 1, 4'd9, 8'h81, 0, 0);
    addVec(0, 1, 4'd9, 8'h90, 0, 0);
    addVec(0, 1, 4'd5, 8'h95, 0, 0);
    addVec(0, 1, 4'd4, 8'h99, 0, 0);
    addVec(0, 1, 4'd1, 8'h00, 1, 0);
    addVec(0, 1, 4'd3, 8'h03, 1, 0);
    addVec(0, 0, 4'd0, 8'h03, 1, 0);
    addVec(1, 0, 4'd0, 8'h00, 0, 0);
    addVec(0, 1, 4'd9, 8'h09, 0, 0);
    addVec(0, 1, 4'd9, 8'h18, 0, 0);
    addVec(0, 1, 4'd9, 8'h27, 0, 0);
    addVec(0, 1, 4'd9, 8'h36, 0, 0);
    addVec(0, 1, 4'd6, 8'h42, 0, 0);
    addVec(0, 1, 4'hA, 8'h42, 0, 1);
    addVec(0, 1, 4'hF, 8'h42, 0, 1);
    addVec(0, 1, 4'd0, 8'h42, 0, 1);
    addVec(1, 0, 4'd0, 8'h00, 0, 0);
    addVec(0, 1, 4'd9, 8'h09, 0, 0);
    addVec(0, 1, 4'd9, 8'h18, 0, 0);
    addVec(0, 1, 4'd9, 8'h27, 0, 0);
    addVec(0, 1, 4'd4, 8'h31, 0, 0);
    addVec(1, 1, 4'd5, 8'h00, 0, 0);
    addVec(0, 1, 4'd6, 8'h06, 0, 0);
    addVec(1, 0, 4'd0, 8'h00, 0, 0);

    // Reset state
    applyStimulus(1, 0, 0, 4'd0);
    checkAccFlags("reset", 8'h00, 0, 0);
    checkOutput("reset.an", {30'd0, an}, 32'h2);
    checkOutput("reset.seg", {25'd0, seg}, {25'd0, 7'b1000000});

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].clr, vecs[i].valid, vecs[i].digit);
      checkAccFlags($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_ovf, vecs[i].exp_err);
    end

    // Build 0x37 and hold it for the scan check
    applyStimulus(0, 0, 1, 4'd9);
    applyStimulus(0, 0, 1, 4'd9);
    applyStimulus(0, 0, 1, 4'd9);
    applyStimulus(0, 0, 1, 4'd9);
    applyStimulus(0, 0, 1, 4'd1);
    checkAccFlags("scan.setup", 8'h37, 0, 0);
    applyStimulus(0, 0, 0, 4'd0);

    // Align on a slot boundary, then expect 4-cycle alternating slots
    start_an = an;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(0, 0, 0, 4'd0);
      if (an !== start_an) found = 1'b1;
    end
    checkOutput("scan.align", {31'd0, found}, 32'd1);
    slot_an = an;
    for (int i = 0; i < 16; i++) begin
      if (((i / 4) % 2) == 1) slot_an = (slot_an == 2'b10) ? 2'b01 : 2'b10;
      slot_seg = (slot_an == 2'b10) ? glyph(4'd7) : glyph(4'd3);
      checkOutput($sformatf("scan.an%0d", i), {30'd0, an}, {30'd0, slot_an});
      checkOutput($sformatf("scan.seg%0d", i), {25'd0, seg}, {25'd0, slot_seg});
      if (((i / 4) % 2) == 1) slot_an = (slot_an == 2'b10) ? 2'b01 : 2'b10;
      applyStimulus(0, 0, 0, 4'd0);
    end

    // Build 0x88, set err, then reset mid-scan with a valid beat present
    applyStimulus(0, 1, 0, 4'd0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 4'd9);
    applyStimulus(0, 0, 1, 4'd7);
    checkAccFlags("mid.setup", 8'h88, 0, 0);
    applyStimulus(0, 0, 1, 4'hB);
    checkAccFlags("mid.err", 8'h88, 0, 1);
    applyStimulus(0, 0, 0, 4'd0);
    applyStimulus(1, 1, 1, 4'd3);
    checkAccFlags("mid.rst", 8'h00, 0, 0);
    checkOutput("mid.rst.an", {30'd0, an}, 32'h2);
    checkOutput("mid.rst.seg", {25'd0, seg}, {25'd0, 7'b1000000});
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'd0);
      checkOutput($sformatf("mid.slot0.an%0d", i), {30'd0, an}, 32'h2);
      checkOutput($sformatf("mid.slot0.seg%0d", i), {25'd0, seg}, {25'd0, glyph(4'd0)});
    end
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("mid.slot1.an", {30'd0, an}, 32'h1);
    checkOutput("mid.slot1.seg", {25'd0, seg}, {25'd0, glyph(4'd0)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bcd_accum_display.md
Name: bcd_accum_display

Overview:
- Downstream consumer of the 4-bit BCD counter/remap stage.
- Accepts one BCD digit per valid cycle and adds it into an NDIG-digit decimal accumulator.
- Flags overflow and illegal (non-BCD) input.
- Drives a time-multiplexed, active-low 7-segment display showing the accumulator value on the lab board.

Parameters:
- NDIG, 2, number of BCD digits in the accumulator and display (legal range 1–4).
- SCAN_DIV, 4, clock cycles per display digit slot (≥1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_digit is presented this cycle.
- in_digit  input  4  BCD digit from the upstream counter stage.
- clr  input  1  synchronous clear of accumulator and flags.
- acc  output  4*NDIG  accumulator, packed BCD; digit k in bits [4k+3:4k], k=0 is units.
- ovf  output  1  sticky decimal overflow flag.
- err  output  1  sticky illegal-digit flag.
- an  output  NDIG  digit enables, active-low one-hot.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst=1 at posedge), all outputs registered:
  - acc=0, ovf=0, err=0.
  - Scan prescaler=0, scan index=0.
  - an = all ones except bit0 = 0.
  - seg = 7'b1000000 (glyph '0').
- Priority each cycle: rst > clr > in_valid.
- clr=1: acc=0, ovf=0, err=0; a concurrent in_valid digit is dropped. Scan logic is unaffected by clr.
- in_valid=1, in_digit ≤ 9:
  - acc <= acc + in_digit in decimal on the next posedge (latency 1).
  - Per-digit add with carry: digit sum >9 → subtract 10, carry 1 to the next digit.
  - Carry out of digit NDIG-1: acc wraps modulo 10^NDIG and ovf <= 1.
- in_valid=1, in_digit ≥ 10: acc unchanged, ovf unchanged, err <= 1.
- in_valid=0: acc holds.
- ovf and err stay set until rst or clr.
- The accumulator never holds a non-BCD nibble.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 every cycle.
  - When it wraps, scan index advances; it wraps from NDIG-1 to 0.
  - an and seg are registered from the scan index and acc in the same cycle. The display therefore shows acc with at most 1 cycle of staleness after an update.
  - an has exactly one 0 bit at all times after reset.
- 7-seg encoding, {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-operation: everything returns to reset values on that edge regardless of in_valid or clr. The first scan slot after reset is digit 0 for a full SCAN_DIV cycles.
- No handshake back-pressure: every valid beat is consumed.

Test Plan:
- rst, then valid digits 7, 8 on consecutive cycles → acc=0x07 one cycle after the first beat, acc=0x15 after the second; ovf=0, err=0.
- From acc=0x95, add 4 → acc=0x99; add 1 → acc=0x00, ovf=1. Add 3 → acc=0x03, ovf stays 1.
- Valid digit 0xA on acc=0x42 → acc=0x42, err=1. Then clr → acc=0x00, err=0, ovf=0.
- clr and in_valid (digit 5) in the same cycle with acc=0x31 → acc=0x00, digit dropped.
- SCAN_DIV=4, acc=0x37 held:
  - an alternates 2'b10 and 2'b01, each held 4 cycles.
  - seg=1111000 while an=2'b10 (units '7').
  - seg=0110000 while an=2'b01 (tens '3').
- Assert rst mid-scan while acc=0x88 → next edge: acc=0, an=2'b10, seg=1000000, and an stays 2'b10 for 4 cycles.
